// File: rtl/sum_splitter.sv
// sum_splitter: splits one SUM_W-bit total into NUM_OPS serial OP_W-bit operands
// whose sum equals the total. A bit-serial restoring divider (SUM_W cycles)
// produces quotient q and remainder r. Operand k is q+1 for k<r, otherwise q.
// Optional feature macro: SPLIT_SAT_EN. When it is defined, an out-of-range total
// is clamped to MAXSUM and split. When it is undefined, the total is dropped.
// In both cases err_o pulses for one cycle.
module sum_splitter #(
    parameter int unsigned SUM_W   = 8,
    parameter int unsigned OP_W    = 6,
    parameter int unsigned NUM_OPS = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_OPS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [SUM_W-1:0] sum_i,
    input  logic             sum_valid_i,
    output logic             sum_ready_o,
    output logic [OP_W-1:0]  op_o,
    output logic [IDX_W-1:0] op_idx_o,
    output logic             op_last_o,
    output logic             op_valid_o,
    input  logic             op_ready_i,
    output logic             err_o
);

    localparam int unsigned REM_W  = IDX_W + 1;
    localparam int unsigned CNT_W  = $clog2(SUM_W + 1);
    localparam int unsigned MAXSUM = NUM_OPS * ((1 << OP_W) - 1);

    localparam logic [REM_W-1:0] DIVISOR  = REM_W'(NUM_OPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SUM_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERR,
        S_DIV,
        S_EMIT
    } state_t;

    state_t             state, state_nxt;
    logic [SUM_W-1:0]   quo, quo_nxt;
    logic [REM_W-1:0]   rem, rem_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               sum_ready_nxt;
    logic [OP_W-1:0]    op_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               last_nxt;
    logic               valid_nxt;
    logic               err_nxt;

    logic [REM_W-1:0]   rem_sh;
    logic               q_bit;
    logic [REM_W-1:0]   rem_step;
    logic [SUM_W-1:0]   quo_step;
    logic [31:0]        sum_wide;
    logic               in_range;
    logic [IDX_W-1:0]   idx_inc;

    // Operand value for index k: the quotient, plus one on the lowest r indices.
    function automatic logic [OP_W-1:0] operand(input logic [SUM_W-1:0] q,
                                                input logic [REM_W-1:0] r,
                                                input logic [IDX_W-1:0] k);
        logic [OP_W-1:0] extra;
        extra = ({1'b0, k} < r) ? OP_W'(1) : '0;
        return OP_W'(q) + extra;
    endfunction

    // Next-state, divider step and registered-output next values.
    always_comb begin
        state_nxt     = state;
        quo_nxt       = quo;
        rem_nxt       = rem;
        cnt_nxt       = cnt;
        sum_ready_nxt = sum_ready_o;
        op_nxt        = op_o;
        idx_nxt       = op_idx_o;
        last_nxt      = op_last_o;
        valid_nxt     = op_valid_o;
        err_nxt       = 1'b0;

        // The dividend register shifts out MSB-first and fills with quotient bits.
        rem_sh   = {rem[REM_W-2:0], quo[SUM_W-1]};
        q_bit    = (rem_sh >= DIVISOR);
        rem_step = q_bit ? (rem_sh - DIVISOR) : rem_sh;
        quo_step = {quo[SUM_W-2:0], q_bit};

        sum_wide = 32'(sum_i);
        in_range = (sum_wide <= MAXSUM);
        idx_inc  = op_idx_o + IDX_W'(1);

        case (state)
            S_IDLE: begin
                if (sum_valid_i && sum_ready_o) begin
                    sum_ready_nxt = 1'b0;
                    rem_nxt       = '0;
                    cnt_nxt       = '0;
                    if (in_range) begin
                        quo_nxt   = sum_i;
                        state_nxt = S_DIV;
                    end else begin
                        err_nxt = 1'b1;
`ifdef SPLIT_SAT_EN
                        quo_nxt   = SUM_W'(MAXSUM);
                        state_nxt = S_DIV;
`else
                        state_nxt = S_ERR;
`endif
                    end
                end
            end
            S_ERR: begin
                sum_ready_nxt = 1'b1;
                state_nxt     = S_IDLE;
            end
            S_DIV: begin
                quo_nxt = quo_step;
                rem_nxt = rem_step;
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == LAST_CNT) begin
                    // The first operand is formed from the final step's result so
                    // that op_valid_o rises right after the last DIV cycle.
                    state_nxt = S_EMIT;
                    valid_nxt = 1'b1;
                    idx_nxt   = '0;
                    op_nxt    = operand(quo_step, rem_step, '0);
                    last_nxt  = 1'b0;
                end
            end
            S_EMIT: begin
                if (op_ready_i) begin
                    if (op_idx_o == LAST_IDX) begin
                        state_nxt     = S_IDLE;
                        valid_nxt     = 1'b0;
                        sum_ready_nxt = 1'b1;
                        op_nxt        = '0;
                        idx_nxt       = '0;
                        last_nxt      = 1'b0;
                    end else begin
                        idx_nxt  = idx_inc;
                        op_nxt   = operand(quo, rem, idx_inc);
                        last_nxt = (idx_inc == LAST_IDX);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            quo         <= '0;
            rem         <= '0;
            cnt         <= '0;
            sum_ready_o <= 1'b1;
            op_o        <= '0;
            op_idx_o    <= '0;
            op_last_o   <= 1'b0;
            op_valid_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_nxt;
            quo         <= quo_nxt;
            rem         <= rem_nxt;
            cnt         <= cnt_nxt;
            sum_ready_o <= sum_ready_nxt;
            op_o        <= op_nxt;
            op_idx_o    <= idx_nxt;
            op_last_o   <= last_nxt;
            op_valid_o  <= valid_nxt;
            err_o       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_sum_splitter.sv
// Directed bench for sum_splitter with hand-computed operand sets.
module tb_sum_splitter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sum;
    logic       sum_valid;
    logic       sum_ready;
    logic [5:0] op;
    logic [1:0] op_idx;
    logic       op_last;
    logic       op_valid;
    logic       op_ready;
    logic       err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    sum_splitter #(.SUM_W(8), .OP_W(6), .NUM_OPS(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sum_i       (sum),
        .sum_valid_i (sum_valid),
        .sum_ready_o (sum_ready),
        .op_o        (op),
        .op_idx_o    (op_idx),
        .op_last_o   (op_last),
        .op_valid_o  (op_valid),
        .op_ready_i  (op_ready),
        .err_o       (err)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sum_ready"}, sum_ready, 1);
        check({tag, "_op"}, op, 0);
        check({tag, "_idx"}, op_idx, 0);
        check({tag, "_last"}, op_last, 0);
        check({tag, "_valid"}, op_valid, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Accepts one total; leaves sum_valid high when hold is set.
    task automatic send(input logic [7:0] value, input bit hold);
        int n = 0;
        while (!sum_ready && n < 100) begin
            tick();
            n++;
        end
        check("ready_timeout", int'(n < 100), 1);
        sum = value;
        sum_valid = 1'b1;
        tick();
        if (!hold) sum_valid = 1'b0;
    endtask

    // Entered in the cycle after accept; checks latency, operands and the drain.
    task automatic expect_ops(input int unsigned e0, input int unsigned e1,
                              input int unsigned e2, input int unsigned e3,
                              input int stall_idx, input int unsigned exp_err);
        int unsigned exp_op[4];
        int n = 1;
        exp_op[0] = e0; exp_op[1] = e1; exp_op[2] = e2; exp_op[3] = e3;
        check("busy_ready", sum_ready, 0);
        check("err_pulse", err, exp_err);
        while (!op_valid && n < 40) begin
            tick();
            n++;
        end
        check("latency", n, 9);
        for (int k = 0; k < 4; k++) begin
            check("op_valid", op_valid, 1);
            check("op_value", op, exp_op[k]);
            check("op_idx", op_idx, k);
            check("op_last", op_last, (k == 3) ? 1 : 0);
            if (k == stall_idx) begin
                op_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("stall_valid", op_valid, 1);
                    check("stall_op", op, exp_op[k]);
                    check("stall_idx", op_idx, k);
                end
                op_ready = 1'b1;
            end
            tick();
        end
        check("drain_valid", op_valid, 0);
        check("drain_ready", sum_ready, 1);
    endtask

    task automatic quiet(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check("quiet_valid", op_valid, 0);
            tick();
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        sum = '0;
        sum_valid = 1'b0;
        op_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("por");

        send(8'd120, 1'b0);
        expect_ops(30, 30, 30, 30, -1, 0);
        send(8'd123, 1'b0);
        expect_ops(31, 31, 31, 30, -1, 0);
        send(8'd5, 1'b0);
        expect_ops(2, 1, 1, 1, -1, 0);
        send(8'd0, 1'b0);
        expect_ops(0, 0, 0, 0, -1, 0);
        send(8'd252, 1'b0);
        expect_ops(63, 63, 63, 63, -1, 0);

        send(8'd253, 1'b0);
`ifdef SPLIT_SAT_EN
        expect_ops(63, 63, 63, 63, -1, 1);
`else
        check("oor_err", err, 1);
        check("oor_ready", sum_ready, 0);
        check("oor_valid", op_valid, 0);
        tick();
        check("oor_err_end", err, 0);
        check("oor_ready_back", sum_ready, 1);
        quiet(12);
`endif

        // Backpressure on operand 1.
        send(8'd123, 1'b0);
        expect_ops(31, 31, 31, 30, 1, 0);

        // sum_valid held with other values while busy; only 5 is taken afterwards.
        send(8'd120, 1'b1);
        sum = 8'd200;
        expect_ops(30, 30, 30, 30, -1, 0);
        sum = 8'd5;
        tick();
        sum_valid = 1'b0;
        expect_ops(2, 1, 1, 1, -1, 0);

        // Reset in the first DIV cycle.
        send(8'd120, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rst_div");
        quiet(12);

        // Reset during EMIT with operand 2 pending.
        send(8'd120, 1'b0);
        n = 0;
        while (!op_valid && n < 40) begin
            tick();
            n++;
        end
        check("emit_timeout", int'(n < 40), 1);
        tick();
        tick();
        check("pre_rst_idx", op_idx, 2);
        op_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        op_ready = 1'b1;
        check_reset_state("rst_emit");
        quiet(12);

        send(8'd120, 1'b0);
        expect_ops(30, 30, 30, 30, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
